// File: rtl/mips_multi_cycle.sv
// Multi-cycle MIPS subset core with one shared memory port and a debug register read port.
// Memory-port outputs are registered and held stable across wait cycles until mem_ready.
module mips_multi_cycle #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter logic [5:0]  HALT_OPCODE = 6'h3F
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  input  logic [4:0]  dbg_sel,
  output logic [31:0] dbg_data,
  output logic [31:0] pc,
  output logic        retired,
  output logic        halted,
  output logic        err
);
  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00, OP_ADDI = 6'h08, OP_LW  = 6'h23, OP_SW = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04, OP_BNE  = 6'h05, OP_J   = 6'h02;
  localparam logic [5:0] F_ADD = 6'h20, F_SUB = 6'h22, F_AND = 6'h24, F_OR = 6'h25;
  localparam logic [5:0] F_NOR = 6'h27, F_SLT = 6'h2A;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d, ir_q, ir_d, a_q, a_d, b_q, b_d, imm_q, imm_d;
  logic [31:0] alu_q, alu_d, mdr_q, mdr_d;
  logic        mem_req_q, mem_req_d, mem_we_q, mem_we_d, err_q, err_d;
  logic [31:0] mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
  logic [31:0] rf_q [32];
  logic        rf_we, enter_fetch;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd;
  logic [31:0] pc_plus4, br_target, eff_addr;

  assign op        = ir_q[31:26];
  assign rs        = ir_q[25:21];
  assign rt        = ir_q[20:16];
  assign rd        = ir_q[15:11];
  assign funct     = ir_q[5:0];
  assign pc_plus4  = pc_q + 32'd4;
  assign br_target = pc_plus4 + {imm_q[29:0], 2'b00};
  assign eff_addr  = a_q + imm_q;

  function automatic logic funct_ok(input logic [5:0] f);
    case (f)
      F_ADD, F_SUB, F_AND, F_OR, F_NOR, F_SLT: funct_ok = 1'b1;
      default:                                 funct_ok = 1'b0;
    endcase
  endfunction

  function automatic logic op_ok(input logic [5:0] o);
    case (o)
      OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J: op_ok = 1'b1;
      default:                                     op_ok = 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] alu_fn(input logic [5:0] f, input logic [31:0] x, input logic [31:0] y);
    case (f)
      F_SUB:   alu_fn = x - y;
      F_AND:   alu_fn = x & y;
      F_OR:    alu_fn = x | y;
      F_NOR:   alu_fn = ~(x | y);
      F_SLT:   alu_fn = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      default: alu_fn = x + y;
    endcase
  endfunction

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ir_d        = ir_q;
    a_d         = a_q;
    b_d         = b_q;
    imm_d       = imm_q;
    alu_d       = alu_q;
    mdr_d       = mdr_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    err_d       = err_q;
    rf_we       = 1'b0;
    rf_waddr    = rt;
    rf_wdata    = alu_q;
    retired     = 1'b0;
    enter_fetch = 1'b0;
    case (state_q)
      S_FETCH: begin
        // Coming out of reset the request is not yet up; raise it first.
        if (!mem_req_q) begin
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = pc_q;
        end else if (mem_ready) begin
          ir_d      = mem_rdata;
          mem_req_d = 1'b0;
          state_d   = S_DECODE;
        end
      end
      S_DECODE: begin
        a_d   = rf_q[rs];
        b_d   = rf_q[rt];
        imm_d = {{16{ir_q[15]}}, ir_q[15:0]};
        if (op == HALT_OPCODE) begin
          state_d = S_HALT;
        end else if ((op == OP_RTYPE) ? !funct_ok(funct) : !op_ok(op)) begin
          state_d = S_HALT;
          err_d   = 1'b1;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        case (op)
          OP_RTYPE: begin alu_d = alu_fn(funct, a_q, b_q); state_d = S_WB; end
          OP_ADDI:  begin alu_d = eff_addr;                state_d = S_WB; end
          OP_LW, OP_SW: begin
            alu_d = eff_addr;
            if (eff_addr[1:0] != 2'b00) begin
              state_d = S_HALT;
              err_d   = 1'b1;
            end else begin
              state_d     = S_MEM;
              mem_req_d   = 1'b1;
              mem_we_d    = (op == OP_SW);
              mem_addr_d  = eff_addr;
              mem_wdata_d = b_q;
            end
          end
          OP_BEQ: begin retired = 1'b1; enter_fetch = 1'b1; pc_d = (a_q == b_q) ? br_target : pc_plus4; end
          OP_BNE: begin retired = 1'b1; enter_fetch = 1'b1; pc_d = (a_q != b_q) ? br_target : pc_plus4; end
          OP_J:   begin retired = 1'b1; enter_fetch = 1'b1; pc_d = {pc_plus4[31:28], ir_q[25:0], 2'b00}; end
          default: begin state_d = S_HALT; err_d = 1'b1; end
        endcase
      end
      S_MEM: begin
        if (mem_ready) begin
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          if (op == OP_LW) begin
            mdr_d   = mem_rdata;
            state_d = S_WB;
          end else begin
            retired     = 1'b1;
            pc_d        = pc_plus4;
            enter_fetch = 1'b1;
          end
        end
      end
      S_WB: begin
        rf_we       = 1'b1;
        rf_waddr    = (op == OP_RTYPE) ? rd : rt;
        rf_wdata    = (op == OP_LW) ? mdr_q : alu_q;
        retired     = 1'b1;
        pc_d        = pc_plus4;
        enter_fetch = 1'b1;
      end
      S_HALT:  state_d = S_HALT;
      default: begin state_d = S_HALT; err_d = 1'b1; end
    endcase
    // Entering FETCH presents the next instruction address in the same edge.
    if (enter_fetch) begin
      state_d    = S_FETCH;
      mem_req_d  = 1'b1;
      mem_we_d   = 1'b0;
      mem_addr_d = pc_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_FETCH;
      pc_q        <= RESET_PC;
      ir_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      imm_q       <= '0;
      alu_q       <= '0;
      mdr_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      err_q       <= 1'b0;
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ir_q        <= ir_d;
      a_q         <= a_d;
      b_q         <= b_d;
      imm_q       <= imm_d;
      alu_q       <= alu_d;
      mdr_q       <= mdr_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      err_q       <= err_d;
      if (rf_we && (rf_waddr != 5'd0)) rf_q[rf_waddr] <= rf_wdata;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign dbg_data  = (dbg_sel == 5'd0) ? 32'd0 : rf_q[dbg_sel];
  assign pc        = pc_q;
  assign halted    = (state_q == S_HALT);
  assign err       = err_q;
endmodule

// File: tb/tb_mips_multi_cycle.sv
// Directed bench for mips_multi_cycle: small programs run from a behavioural memory
// with per-region ready latency; results checked through the debug port and monitors.
module tb_mips_multi_cycle;
  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        mem_req, mem_we, mem_ready, retired, halted, err;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, dbg_data, pc;
  logic [4:0]  dbg_sel = 5'd0;

  mips_multi_cycle dut (
    .clk(clk), .reset_n(reset_n),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .dbg_sel(dbg_sel), .dbg_data(dbg_data),
    .pc(pc), .retired(retired), .halted(halted), .err(err)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [64];
  int          inst_dly = 0, data_dly = 0, wait_cnt = 0;
  int          wr_count = 0;
  logic [31:0] wr_addr, wr_data, pend_addr, pend_wdata;
  logic        pend_we = 1'b0;
  int          cyc = 0, req_cycles = 0, ret_n = 0;
  int          ret_cyc [16];
  logic [31:0] pc_after [16];
  logic        ret_prev = 1'b0;
  int          passes = 0, fails = 0, total = 0;

  // Memory responder: updates just after each rising edge.
  initial begin
    mem_ready = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (!reset_n) begin
        mem_ready = 1'b0;
        wait_cnt  = 0;
      end else begin
        if (mem_ready) begin
          if (pend_we) begin
            mem[pend_addr[7:2]] = pend_wdata;
            wr_count++;
            wr_addr = pend_addr;
            wr_data = pend_wdata;
          end
          wait_cnt = 0;
        end
        if (mem_req && wait_cnt >= ((mem_addr >= 32'h40) ? data_dly : inst_dly)) begin
          mem_ready  = 1'b1;
          mem_rdata  = mem[mem_addr[7:2]];
          pend_we    = mem_we;
          pend_addr  = mem_addr;
          pend_wdata = mem_wdata;
        end else begin
          mem_ready = 1'b0;
          if (mem_req) wait_cnt++;
        end
      end
    end
  end

  // Monitor: counts cycles, request cycles, retire times and pc after each retire.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (mem_req) req_cycles++;
      if (ret_prev && ret_n >= 1 && ret_n <= 16) pc_after[ret_n-1] = pc;
      if (retired) begin
        if (ret_n < 16) ret_cyc[ret_n] = cyc;
        ret_n++;
      end
      ret_prev = retired;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic read_reg(input logic [4:0] r, output logic [31:0] v);
    dbg_sel = r;
    #1;
    v = dbg_data;
  endtask

  task automatic hold_reset();
    reset_n = 1'b0;
    step(2);
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
  endtask

  task automatic release_reset();
    cyc = 0; req_cycles = 0; ret_n = 0; ret_prev = 1'b0; wr_count = 0;
    for (int i = 0; i < 16; i++) begin ret_cyc[i] = 0; pc_after[i] = 32'h0; end
    reset_n = 1'b1;
    #1;
  endtask

  task automatic wait_halt(input string tag, input int max);
    int n = 0;
    while (!halted && n < max) begin step(1); n++; end
    check(tag, halted, 1'b1);
  endtask

  function automatic logic [31:0] enc_i(input logic [5:0] o, input logic [4:0] s, input logic [4:0] t, input logic [15:0] im);
    return {o, s, t, im};
  endfunction
  function automatic logic [31:0] enc_r(input logic [4:0] s, input logic [4:0] t, input logic [4:0] d, input logic [5:0] f);
    return {6'h00, s, t, d, 5'h00, f};
  endfunction
  localparam logic [31:0] HALT_W = 32'hFC00_0000;

  logic [31:0] v;
  int          nz;

  initial begin
    // Reset values
    #1 reset_n = 1'b0;
    #1;
    check("rst_mem_req", mem_req, 1'b0);
    check("rst_mem_we", mem_we, 1'b0);
    check("rst_retired", retired, 1'b0);
    check("rst_halted", halted, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_pc", pc, 32'h0);
    read_reg(5'd5, v); check("rst_reg5", v, 32'h0);

    // addi/addi/add/halt with ready tied high
    hold_reset();
    inst_dly = 0; data_dly = 0;
    mem[0] = enc_i(6'h08, 5'd0, 5'd8, 16'd5);
    mem[1] = enc_i(6'h08, 5'd0, 5'd9, 16'hFFFD);
    mem[2] = enc_r(5'd8, 5'd9, 5'd10, 6'h20);
    mem[3] = HALT_W;
    release_reset();
    check("post_rst_req_low", mem_req, 1'b0);
    step(1);
    check("first_fetch_req", mem_req, 1'b1);
    check("first_fetch_addr", mem_addr, 32'h0);
    check("first_fetch_we", mem_we, 1'b0);
    step(13);
    check("halted_at_14", halted, 1'b0);
    step(1);
    check("halted_at_15", halted, 1'b1);
    check("p1_err", err, 1'b0);
    check("p1_retired_cnt", ret_n, 3);
    check("p1_first_retire_cyc", ret_cyc[0], 4);
    read_reg(5'd10, v); check("p1_r10", v, 32'h2);
    read_reg(5'd9, v);  check("p1_r9", v, 32'hFFFF_FFFD);
    check("p1_halt_pc", pc, 32'hC);
    check("p1_halt_req", mem_req, 1'b0);

    // ALU ops, slt signedness and branches, with one fetch wait cycle
    hold_reset();
    inst_dly = 1; data_dly = 0;
    mem[0]  = enc_i(6'h08, 5'd0, 5'd8, 16'd5);
    mem[1]  = enc_i(6'h08, 5'd0, 5'd9, 16'hFFFD);
    mem[2]  = enc_r(5'd8, 5'd9, 5'd12, 6'h22);
    mem[3]  = enc_r(5'd8, 5'd9, 5'd13, 6'h24);
    mem[4]  = enc_r(5'd8, 5'd9, 5'd14, 6'h25);
    mem[5]  = enc_r(5'd8, 5'd9, 5'd15, 6'h27);
    mem[6]  = enc_r(5'd9, 5'd8, 5'd16, 6'h2A);
    mem[7]  = enc_r(5'd8, 5'd9, 5'd17, 6'h2A);
    mem[8]  = enc_i(6'h04, 5'd8, 5'd9, 16'd5);
    mem[9]  = enc_i(6'h05, 5'd8, 5'd9, 16'd1);
    mem[10] = enc_i(6'h08, 5'd0, 5'd18, 16'd1);
    mem[11] = HALT_W;
    release_reset();
    wait_halt("p2_halt_timeout", 300);
    read_reg(5'd12, v); check("p2_sub", v, 32'h8);
    read_reg(5'd13, v); check("p2_and", v, 32'h5);
    read_reg(5'd14, v); check("p2_or", v, 32'hFFFF_FFFD);
    read_reg(5'd15, v); check("p2_nor", v, 32'h2);
    read_reg(5'd16, v); check("p2_slt_true", v, 32'h1);
    read_reg(5'd17, v); check("p2_slt_false", v, 32'h0);
    read_reg(5'd18, v); check("p2_skipped", v, 32'h0);
    check("p2_err", err, 1'b0);
    check("p2_pc", pc, 32'h2C);
    check("p2_retired_cnt", ret_n, 10);
    check("p2_addi_cycles_wait", ret_cyc[1] - ret_cyc[0], 5);

    // sw then lw with 3 data wait cycles per access
    hold_reset();
    inst_dly = 0; data_dly = 3;
    mem[0]  = enc_i(6'h23, 5'd0, 5'd8, 16'h44);
    mem[1]  = enc_i(6'h2B, 5'd0, 5'd8, 16'h40);
    mem[2]  = enc_i(6'h23, 5'd0, 5'd11, 16'h40);
    mem[3]  = HALT_W;
    mem[17] = 32'hDEAD_BEEF;
    release_reset();
    wait_halt("p3_halt_timeout", 200);
    check("p3_wr_count", wr_count, 1);
    check("p3_wr_addr", wr_addr, 32'h40);
    check("p3_wr_data", wr_data, 32'hDEAD_BEEF);
    read_reg(5'd11, v); check("p3_r11", v, 32'hDEAD_BEEF);
    check("p3_sw_cycles", ret_cyc[1] - ret_cyc[0], 7);
    check("p3_lw_cycles", ret_cyc[2] - ret_cyc[1], 8);
    check("p3_err", err, 1'b0);

    // bne not taken, j, then beq loop to itself
    hold_reset();
    inst_dly = 0; data_dly = 0;
    mem[0] = enc_i(6'h05, 5'd0, 5'd0, 16'd4);
    mem[1] = {6'h02, 26'h4};
    mem[4] = enc_i(6'h04, 5'd0, 5'd0, 16'hFFFF);
    release_reset();
    step(20);
    check("p4_bne_retire_cyc", ret_cyc[0], 3);
    check("p4_bne_pc", pc_after[0], 32'h4);
    check("p4_j_pc", pc_after[1], 32'h10);
    check("p4_beq_pc_a", pc_after[2], 32'h10);
    check("p4_beq_pc_b", pc_after[3], 32'h10);
    check("p4_j_cycles", ret_cyc[1] - ret_cyc[0], 3);
    check("p4_beq_cycles_a", ret_cyc[2] - ret_cyc[1], 3);
    check("p4_beq_cycles_b", ret_cyc[3] - ret_cyc[2], 3);
    check("p4_not_halted", halted, 1'b0);

    // Misaligned lw halts with err and no data request
    hold_reset();
    mem[0] = enc_i(6'h23, 5'd0, 5'd9, 16'd2);
    release_reset();
    wait_halt("p5_halt_timeout", 50);
    check("p5_err", err, 1'b1);
    check("p5_req_cycles", req_cycles, 1);
    check("p5_pc", pc, 32'h0);
    check("p5_retired_cnt", ret_n, 0);

    // Reset during a pending sw transfer
    hold_reset();
    inst_dly = 0; data_dly = 100;
    mem[0] = enc_i(6'h08, 5'd0, 5'd8, 16'd5);
    mem[1] = enc_i(6'h2B, 5'd0, 5'd8, 16'h40);
    release_reset();
    begin
      int n = 0;
      while (!(mem_req && mem_we) && n < 50) begin step(1); n++; end
    end
    check("p6_sw_pending_we", mem_we, 1'b1);
    check("p6_sw_addr", mem_addr, 32'h40);
    check("p6_sw_wdata", mem_wdata, 32'h5);
    read_reg(5'd8, v); check("p6_r8_before", v, 32'h5);
    step(2);
    check("p6_still_pending", mem_req, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    check("p6_req_dropped", mem_req, 1'b0);
    check("p6_pc_reset", pc, 32'h0);
    nz = 0;
    for (int r = 0; r < 32; r++) begin
      read_reg(r[4:0], v);
      if (v != 32'h0) nz++;
    end
    check("p6_regs_zero", nz, 0);
    step(3);
    check("p6_no_write", wr_count, 0);

    // Write to $0 discarded; then unsupported funct
    hold_reset();
    data_dly = 0;
    mem[0] = enc_i(6'h08, 5'd0, 5'd0, 16'd7);
    mem[1] = HALT_W;
    release_reset();
    wait_halt("p7_halt_timeout", 50);
    read_reg(5'd0, v); check("p7_r0", v, 32'h0);
    check("p7_err", err, 1'b0);
    check("p7_retired_cnt", ret_n, 1);
    hold_reset();
    mem[0] = enc_r(5'd0, 5'd0, 5'd1, 6'h01);
    release_reset();
    wait_halt("p8_halt_timeout", 50);
    check("p8_err", err, 1'b1);
    step(3);
    check("p8_still_halted", halted, 1'b1);
    check("p8_err_sticky", err, 1'b1);
    check("p8_req_low", mem_req, 1'b0);
    check("p8_pc_frozen", pc, 32'h0);
    check("p8_retired_cnt", ret_n, 0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
